// File: rtl/touch_detector_if.sv
// rtl/touch_detector_if.sv - sensor/processor side signals of the touch detector
interface touch_detector_if #(
    parameter int N_CH = 9,
    parameter int W    = 32
);
    logic [N_CH*W-1:0] readings;
    logic              recal;
    logic [N_CH-1:0]   clear_mask;
    logic [N_CH-1:0]   touched;
    logic [N_CH-1:0]   press_pending;
    logic              scan_done;
    logic              busy;

    modport master (
        output readings, recal, clear_mask,
        input  touched, press_pending, scan_done, busy
    );

    modport slave (
        input  readings, recal, clear_mask,
        output touched, press_pending, scan_done, busy
    );
endinterface

// File: rtl/touch_detector.sv
// rtl/touch_detector.sv - periodic capacitive touch sweep with baseline tracking,
// hysteresis and debounce; one shared subtractor walks the channels one per cycle.
module touch_detector #(
    parameter int N_CH       = 9,
    parameter int W          = 32,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int THRESH_ON  = 200,
    parameter int THRESH_OFF = 100,
    parameter int BASE_SHIFT = 4
) (
    input  logic         clock,
    input  logic         reset,
    touch_detector_if.slave bus
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic               cal_pending_q, cal_pending_d;
    logic               cal_sweep_q, cal_sweep_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       snap_q [N_CH];
    logic [W-1:0]       snap_d [N_CH];
    logic [W-1:0]       base_q [N_CH];
    logic [W-1:0]       base_d [N_CH];
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0]    touched_q, touched_d;
    logic [N_CH-1:0]    press_q, press_d;
    logic               scan_done_q, scan_done_d;

    logic [W-1:0]       r, b, delta;
    logic signed [W:0]  diff, diff_sh;
    logic               cur_t, raw_on, raw_off, disagree, hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               div_last;

    // Shared per-channel datapath for the channel under evaluation.
    always_comb begin
        r        = snap_q[idx_q];
        b        = base_q[idx_q];
        cur_t    = touched_q[idx_q];
        diff     = $signed({1'b0, r}) - $signed({1'b0, b});
        diff_sh  = diff >>> BASE_SHIFT;
        delta    = diff[W] ? '0 : diff[W-1:0];
        raw_on   = delta > W'(THRESH_ON);
        raw_off  = delta < W'(THRESH_OFF);
        disagree = cur_t ? raw_off : raw_on;
        cnt_inc  = cnt_q[idx_q] + 1'b1;
        hit      = disagree && (cnt_inc == CNT_W'(DEBOUNCE));
        div_last = (div_q == DIV_W'(SAMPLE_DIV - 1));
    end

    always_comb begin
        state_d       = state_q;
        cal_pending_d = cal_pending_q | bus.recal;
        cal_sweep_d   = cal_sweep_q;
        div_d         = div_last ? '0 : div_q + 1'b1;
        idx_d         = idx_q;
        snap_d        = snap_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        touched_d     = touched_q;
        press_d       = press_q & ~bus.clear_mask;
        scan_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_last) begin
                    for (int k = 0; k < N_CH; k++) snap_d[k] = bus.readings[k*W +: W];
                    idx_d         = '0;
                    state_d       = SCAN;
                    // The sweep's mode is frozen here; a recal seen later waits for the next sweep.
                    cal_sweep_d   = cal_pending_q | bus.recal;
                    cal_pending_d = 1'b0;
                end
            end
            SCAN: begin
                if (cal_sweep_q) begin
                    base_d[idx_q]    = r;
                    cnt_d[idx_q]     = '0;
                    touched_d[idx_q] = 1'b0;
                end else begin
                    if (!cur_t && !raw_on) base_d[idx_q] = W'($unsigned(diff_sh) + {1'b0, b});
                    if (!disagree) begin
                        cnt_d[idx_q] = '0;
                    end else if (hit) begin
                        cnt_d[idx_q]     = '0;
                        touched_d[idx_q] = ~cur_t;
                        if (!cur_t) press_d[idx_q] = 1'b1;
                    end else begin
                        cnt_d[idx_q] = cnt_inc;
                    end
                end
                if (idx_q == IDX_W'(N_CH - 1)) begin
                    state_d     = IDLE;
                    scan_done_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cal_pending_q <= 1'b1;
            cal_sweep_q   <= 1'b0;
            div_q         <= '0;
            idx_q         <= '0;
            touched_q     <= '0;
            press_q       <= '0;
            scan_done_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                snap_q[k] <= '0;
                base_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            cal_pending_q <= cal_pending_d;
            cal_sweep_q   <= cal_sweep_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            touched_q     <= touched_d;
            press_q       <= press_d;
            scan_done_q   <= scan_done_d;
            snap_q        <= snap_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.touched       = touched_q;
    assign bus.press_pending = press_q;
    assign bus.scan_done     = scan_done_q;
    assign bus.busy          = (state_q == SCAN);
endmodule

// File: tb/tb_touch_detector.sv
// tb/tb_touch_detector.sv - scoreboard bench for touch_detector with a per-sweep reference model
module tb_touch_detector;
    localparam int N_CH = 9;
    localparam int W    = 32;
    localparam int SD   = 16;
    localparam int DB   = 3;
    localparam int TON  = 200;
    localparam int TOFF = 100;
    localparam int BS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    touch_detector_if #(.N_CH(N_CH), .W(W)) bus ();

    touch_detector #(
        .N_CH(N_CH), .W(W), .SAMPLE_DIV(SD), .DEBOUNCE(DB),
        .THRESH_ON(TON), .THRESH_OFF(TOFF), .BASE_SHIFT(BS)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [N_CH-1:0]   t;
        logic [N_CH-1:0]   p;
        logic [N_CH*W-1:0] base;
        logic [N_CH*8-1:0] cnt;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;

    longint rd     [N_CH];
    longint mbase  [N_CH];
    int     mcnt   [N_CH];
    bit     mtouch [N_CH];
    bit     mpress [N_CH];
    bit     mcal;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_shift(input longint d);
        longint q;
        q = 64'sd1 << BS;
        if (d >= 0) return d / q;
        return -((-d + q - 1) / q);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N_CH; k++) begin
            mbase[k] = 0; mcnt[k] = 0; mtouch[k] = 0; mpress[k] = 0;
        end
        mcal = 1;
    endfunction

    // Whole-sweep behaviour: calibration copies readings, detection applies hysteresis/debounce/drift.
    function automatic void model_sweep();
        exp_t   e;
        longint d, delta;
        bit     on, off, dis, upd;
        for (int k = 0; k < N_CH; k++) begin
            if (mcal) begin
                mbase[k] = rd[k]; mcnt[k] = 0; mtouch[k] = 0;
            end else begin
                d     = rd[k] - mbase[k];
                delta = (d < 0) ? 0 : d;
                on    = delta > TON;
                off   = delta < TOFF;
                dis   = mtouch[k] ? off : on;
                upd   = !mtouch[k] && !on;
                if (upd) mbase[k] = mbase[k] + floor_shift(d);
                if (dis) begin
                    mcnt[k]++;
                    if (mcnt[k] == DB) begin
                        mcnt[k]   = 0;
                        mtouch[k] = !mtouch[k];
                        if (mtouch[k]) mpress[k] = 1;
                    end
                end else begin
                    mcnt[k] = 0;
                end
            end
            e.t[k]            = mtouch[k];
            e.p[k]            = mpress[k];
            e.base[k*W +: W]  = 32'(mbase[k]);
            e.cnt[k*8 +: 8]   = 8'(mcnt[k]);
        end
        mcal = 0;
        sbq.push_back(e);
    endfunction

    task automatic start_sweep();
        for (int k = 0; k < N_CH; k++) bus.readings[k*W +: W] = 32'(rd[k]);
        model_sweep();
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 4*SD; i++) begin
            @(negedge clk);
            if (bus.scan_done) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_done_timeout: got none expected pulse"); end
    endtask

    task automatic wait_busy();
        bit ok = 0;
        for (int i = 0; i < 4*SD; i++) begin
            @(negedge clk);
            if (bus.busy) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_timeout: got none expected busy"); end
    endtask

    task automatic run_sweep();
        start_sweep();
        wait_done();
    endtask

    task automatic idle_pulse(input logic [N_CH-1:0] cm, input bit rc);
        bus.clear_mask = cm;
        bus.recal      = rc;
        for (int k = 0; k < N_CH; k++) if (cm[k]) mpress[k] = 0;
        if (rc) mcal = 1;
        @(negedge clk);
        bus.clear_mask = '0;
        bus.recal      = 1'b0;
    endtask

    // kind 0: clear_mask[3] in ch3's evaluation cycle; kind 1: recal mid-sweep
    task automatic timed_sweep(input int kind, input int off);
        start_sweep();
        wait_busy();
        repeat (off) @(negedge clk);
        if (kind == 0) bus.clear_mask = N_CH'(1) << 3;
        else           bus.recal = 1'b1;
        @(negedge clk);
        bus.clear_mask = '0;
        bus.recal      = 1'b0;
        if (kind == 1) mcal = 1;
        wait_done();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_touched"}, bus.touched, 0);
        chk({tag, "_press"}, bus.press_pending, 0);
        chk({tag, "_scan_done"}, bus.scan_done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    int gcyc = 0, since_rst = 0, last_done = 0, busy_run = 0;
    bit first_after_rst = 1, have_prev = 0;

    always @(negedge clk) begin
        exp_t e;
        gcyc++;
        if (rst) begin
            since_rst = 0; first_after_rst = 1; have_prev = 0; busy_run = 0;
        end else begin
            since_rst++;
            if (bus.busy) busy_run++;
            if (bus.scan_done) begin
                chk("busy_low_at_done", bus.busy, 0);
                chk("busy_cycles", busy_run, N_CH);
                if (first_after_rst) chk("first_sweep_delay", since_rst, SD + N_CH);
                if (have_prev) chk("sweep_period", gcyc - last_done, SD);
                have_prev = 1; first_after_rst = 0; last_done = gcyc; busy_run = 0;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_scan_done: got pulse expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("touched", bus.touched, e.t);
                    chk("press_pending", bus.press_pending, e.p);
                    for (int k = 0; k < N_CH; k++) begin
                        chk($sformatf("baseline%0d", k), dut.base_q[k], e.base[k*W +: W]);
                        chk($sformatf("debounce%0d", k), int'(dut.cnt_q[k]), int'(e.cnt[k*8 +: 8]));
                    end
                end
            end
        end
    end

    initial begin
        bus.readings   = '0;
        bus.recal      = 1'b0;
        bus.clear_mask = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        for (int k = 0; k < N_CH; k++) rd[k] = 1000;
        run_sweep();

        // Press on ch3, glitch on ch5, upward drift on ch0, negative delta on ch1.
        rd[3] = 1300; rd[5] = 1300; rd[0] = 1160; rd[1] = 900;
        run_sweep();
        run_sweep();
        rd[5] = 1000;
        run_sweep();

        rd[3] = 1150;
        repeat (5) run_sweep();
        rd[3] = 1050;
        repeat (3) run_sweep();

        idle_pulse(N_CH'(1) << 3, 1'b0);
        run_sweep();

        rd[3] = 1300;
        run_sweep();
        run_sweep();
        timed_sweep(0, 3);

        timed_sweep(1, 2);
        run_sweep();

        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 3) == 0)
                idle_pulse(N_CH'($urandom), $urandom_range(0, 7) == 0);
            for (int k = 0; k < N_CH; k++)
                rd[k] = ($urandom_range(0, 2) == 0) ? 1000 + $urandom_range(150, 500)
                                                    : 900 + $urandom_range(0, 250);
            run_sweep();
        end

        start_sweep();
        wait_busy();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check_outputs_zero("mid_scan_reset");
        sbq.delete();
        model_reset();
        @(negedge clk);
        check_outputs_zero("held_reset");
        @(negedge clk);
        #2 rst = 1'b0;

        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < N_CH; k++) rd[k] = 950 + $urandom_range(0, 400);
            run_sweep();
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
